// File: rtl/tdm_demux4.sv
// tdm_demux4: four-slot TDM demultiplexer with sync-based frame lock.
// Samples for slots 0..2 are staged; the slot-3 sample releases the full
// frame to o0..o3 on the same edge it is accepted.
module tdm_demux4 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic             frame_valid,
  output logic [1:0]       slot,
  output logic             locked,
  output logic             sync_err
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] stage_q [3];

  // Per-cycle decode results consumed by the datapath registers
  logic             capture;
  logic [1:0]       cap_idx;
  logic             frame_done;
  logic             resync;

  // Lock state and slot counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  // Next-state decode; cycles without din_valid leave everything untouched
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    capture    = 1'b0;
    cap_idx    = 2'd0;
    frame_done = 1'b0;
    resync     = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (sync) begin
            capture = 1'b1;
            cap_idx = 2'd0;
            slot_d  = 2'd1;
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (sync && (slot_q != 2'd0)) begin
            // Misplaced sync restarts the frame with this sample as slot 0
            resync  = 1'b1;
            capture = 1'b1;
            cap_idx = 2'd0;
            slot_d  = 2'd1;
          end else if (slot_q == 2'd3) begin
            frame_done = 1'b1;
            slot_d     = 2'd0;
          end else begin
            capture = 1'b1;
            cap_idx = slot_q;
            slot_d  = slot_q + 2'd1;
          end
        end
        default: begin
          state_d = HUNT;
          slot_d  = '0;
        end
      endcase
    end
  end

  // Staging registers for slots 0..2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 3; i++) begin
        stage_q[i] <= '0;
      end
    end else if (capture) begin
      stage_q[cap_idx] <= din;
    end
  end

  // Output channels load only on a completed frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o0 <= '0;
      o1 <= '0;
      o2 <= '0;
      o3 <= '0;
    end else if (frame_done) begin
      o0 <= stage_q[0];
      o1 <= stage_q[1];
      o2 <= stage_q[2];
      o3 <= din;
    end
  end

  // Single-cycle status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= frame_done;
      sync_err    <= resync;
    end
  end

  assign slot   = slot_q;
  assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed scenario tests for tdm_demux4 (WIDTH=8).
module tb_tdm_demux4;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       sync;
  logic [7:0] o0, o1, o2, o3;
  logic       frame_valid;
  logic [1:0] slot;
  logic       locked;
  logic       sync_err;

  int errors = 0;
  int checks = 0;

  tdm_demux4 #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .sync        (sync),
    .o0          (o0),
    .o1          (o1),
    .o2          (o2),
    .o3          (o3),
    .frame_valid (frame_valid),
    .slot        (slot),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of input at the falling edge, then sample 1 time unit
  // after the following rising edge.
  task automatic send(input logic [7:0] d, input logic s, input logic v);
    @(negedge clk);
    din       = d;
    sync      = s;
    din_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    din_valid = 1'b0;
    sync      = 1'b0;
    din       = '0;
    rst_n     = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    din = '0; din_valid = 1'b0; sync = 1'b0;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({o0, o1, o2, o3} !== 32'h0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=%h", {o0, o1, o2, o3}, 32'h0);
    end
    checks++;
    if ({frame_valid, sync_err, locked, slot} !== 5'b0) begin
      errors++; $display("FAIL reset_status got=%b exp=%b", {frame_valid, sync_err, locked, slot}, 5'b0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_lock();
    send(8'h11, 1'b1, 1'b1);
    checks++;
    if ({locked, slot, frame_valid} !== 4'b1_01_0) begin
      errors++; $display("FAIL lock_first got=%b exp=%b", {locked, slot, frame_valid}, 4'b1010);
    end
    send(8'h22, 1'b0, 1'b1);
    send(8'h33, 1'b0, 1'b1);
    checks++;
    if ({slot, frame_valid} !== 3'b11_0) begin
      errors++; $display("FAIL lock_slot3 got=%b exp=%b", {slot, frame_valid}, 3'b110);
    end
    send(8'h44, 1'b0, 1'b1);
    checks++;
    if ({o0, o1, o2, o3} !== 32'h11223344) begin
      errors++; $display("FAIL lock_outputs got=%h exp=%h", {o0, o1, o2, o3}, 32'h11223344);
    end
    checks++;
    if ({frame_valid, locked, slot} !== 4'b1_1_00) begin
      errors++; $display("FAIL lock_fv got=%b exp=%b", {frame_valid, locked, slot}, 4'b1100);
    end
    send(8'h00, 1'b0, 1'b0);
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++; $display("FAIL lock_fv_pulse got=%b exp=%b", frame_valid, 1'b0);
    end
  endtask

  task automatic test_hunt();
    apply_reset();
    send(8'hAA, 1'b0, 1'b1);
    send(8'hBB, 1'b0, 1'b1);
    checks++;
    if ({locked, slot} !== 3'b0_00) begin
      errors++; $display("FAIL hunt_discard got=%b exp=%b", {locked, slot}, 3'b000);
    end
    send(8'h01, 1'b1, 1'b1);
    send(8'h02, 1'b0, 1'b1);
    send(8'h03, 1'b0, 1'b1);
    send(8'h04, 1'b0, 1'b1);
    checks++;
    if ({o0, o1, o2, o3, frame_valid} !== {32'h01020304, 1'b1}) begin
      errors++; $display("FAIL hunt_frame got=%h/%b exp=01020304/1", {o0, o1, o2, o3}, frame_valid);
    end
    send(8'h00, 1'b0, 1'b0);
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++; $display("FAIL hunt_single_fv got=%b exp=%b", frame_valid, 1'b0);
    end
  endtask

  task automatic test_gaps();
    for (int k = 0; k < 4; k++) begin
      send(8'h10 + 8'(k), 1'b0, 1'b1);
      for (int g = 0; g < 2; g++) begin
        send(8'hEE, 1'b1, 1'b0);
        checks++;
        if (slot !== 2'((k + 1) % 4)) begin
          errors++; $display("FAIL gap_slot_hold k=%0d got=%0d exp=%0d", k, slot, (k + 1) % 4);
        end
        checks++;
        if (frame_valid !== 1'b0) begin
          errors++; $display("FAIL gap_fv k=%0d g=%0d got=%b exp=0", k, g, frame_valid);
        end
      end
      if (k < 3) begin
        checks++;
        if ({o0, o1, o2, o3} !== 32'h01020304) begin
          errors++; $display("FAIL gap_hold k=%0d got=%h exp=%h", k, {o0, o1, o2, o3}, 32'h01020304);
        end
      end
    end
    checks++;
    if ({o0, o1, o2, o3} !== 32'h10111213) begin
      errors++; $display("FAIL gap_outputs got=%h exp=%h", {o0, o1, o2, o3}, 32'h10111213);
    end
  endtask

  task automatic test_resync();
    send(8'h50, 1'b0, 1'b1);
    send(8'h51, 1'b0, 1'b1);
    send(8'h60, 1'b1, 1'b1);
    checks++;
    if ({sync_err, slot, frame_valid, locked} !== 5'b1_01_0_1) begin
      errors++; $display("FAIL resync_err got=%b exp=%b", {sync_err, slot, frame_valid, locked}, 5'b10101);
    end
    checks++;
    if ({o0, o1, o2, o3} !== 32'h10111213) begin
      errors++; $display("FAIL resync_hold got=%h exp=%h", {o0, o1, o2, o3}, 32'h10111213);
    end
    send(8'h61, 1'b0, 1'b1);
    checks++;
    if (sync_err !== 1'b0) begin
      errors++; $display("FAIL resync_pulse got=%b exp=%b", sync_err, 1'b0);
    end
    send(8'h62, 1'b0, 1'b1);
    send(8'h63, 1'b0, 1'b1);
    checks++;
    if ({o0, o1, o2, o3, frame_valid} !== {32'h60616263, 1'b1}) begin
      errors++; $display("FAIL resync_frame got=%h/%b exp=60616263/1", {o0, o1, o2, o3}, frame_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic [31:0] exp_frame;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) begin
        d = 8'h80 + 8'(f * 16) + 8'(k);
        exp_frame = {d - 8'd3, d - 8'd2, d - 8'd1, d};
        send(d, 1'b0, 1'b1);
        checks++;
        if (frame_valid !== (k == 3)) begin
          errors++; $display("FAIL b2b_fv f=%0d k=%0d got=%b exp=%b", f, k, frame_valid, k == 3);
        end
        if (k == 3) begin
          checks++;
          if ({o0, o1, o2, o3} !== exp_frame) begin
            errors++; $display("FAIL b2b_frame f=%0d got=%h exp=%h", f, {o0, o1, o2, o3}, exp_frame);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    send(8'h01, 1'b1, 1'b1);
    send(8'h02, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o0, o1, o2, o3} !== 32'h0) begin
      errors++; $display("FAIL midrst_outputs got=%h exp=%h", {o0, o1, o2, o3}, 32'h0);
    end
    checks++;
    if ({locked, slot, frame_valid, sync_err} !== 5'b0) begin
      errors++; $display("FAIL midrst_status got=%b exp=%b", {locked, slot, frame_valid, sync_err}, 5'b0);
    end
    rst_n = 1'b1;
    send(8'h03, 1'b0, 1'b1);
    send(8'h04, 1'b0, 1'b1);
    checks++;
    if ({locked, slot, frame_valid} !== 4'b0) begin
      errors++; $display("FAIL midrst_hunt got=%b exp=%b", {locked, slot, frame_valid}, 4'b0);
    end
    checks++;
    if ({o0, o1, o2, o3} !== 32'h0) begin
      errors++; $display("FAIL midrst_nocapture got=%h exp=%h", {o0, o1, o2, o3}, 32'h0);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_hunt();
    test_gaps();
    test_resync();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
